// File: rtl/miniled_refresh_scheduler.sv
// MiniLED refresh scheduler: a double-buffered zone store streamed line by line
// to the driver chain, followed by latch, scan-hold and blank phases per line.
`timescale 1ns/1ps
module miniled_refresh_scheduler #(
   parameter int ZONES     = 360,
   parameter int SCANS     = 4,
   parameter int ZPL       = 90,
   parameter int DW        = 8,
   parameter int LE_CYC    = 2,
   parameter int HOLD_CYC  = 1024,
   parameter int BLANK_CYC = 16
) (
   input  logic             I_clk,
   input  logic             I_rst,
   input  logic             I_enable,
   input  logic [1:0]       I_led_mode,
   input  logic             I_wr_en,
   input  logic [8:0]       I_wr_addr,
   input  logic [DW-1:0]    I_wr_data,
   input  logic             I_frame_done,
   output logic             O_zone_valid,
   input  logic             I_zone_ready,
   output logic [DW-1:0]    O_zone_data,
   output logic [6:0]       O_zone_idx,
   output logic             O_le,
   output logic [SCANS-1:0] O_scan,
   output logic             O_swap,
   output logic             O_overrun,
   output logic             O_busy
);
   localparam int CMAX_A = (LE_CYC > BLANK_CYC) ? LE_CYC : BLANK_CYC;
   localparam int CMAX   = (HOLD_CYC > CMAX_A) ? HOLD_CYC : CMAX_A;
   localparam int CW     = $clog2(CMAX + 1);
   localparam int LW     = (SCANS > 1) ? $clog2(SCANS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY, S_BLANK} state_t;

   state_t        r_state, w_state_nxt;
   logic [LW-1:0] r_line, w_line_nxt;
   logic [6:0]    r_k, w_k_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_mode, w_mode_nxt;
   logic          r_bank, w_bank_nxt;
   logic          r_pend, r_swap, r_ovr;
   logic          w_load, w_swap;
   logic [DW-1:0] r_data, w_data_nxt;
   logic [8:0]    w_rd_addr;
   logic [DW-1:0] r_mem [2][ZONES];

   always_comb begin
      w_state_nxt = r_state;
      w_line_nxt  = r_line;
      w_k_nxt     = r_k;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      w_bank_nxt  = r_bank;
      w_load      = 1'b0;
      w_swap      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (I_enable) begin
               w_state_nxt = S_SHIFT;
               w_line_nxt  = '0;
               w_k_nxt     = '0;
               w_mode_nxt  = I_led_mode;
               w_load      = 1'b1;
            end
         end
         S_SHIFT: begin
            if (I_zone_ready) begin
               if (r_k == 7'(ZPL - 1)) begin
                  w_state_nxt = S_LATCH;
                  w_cnt_nxt   = '0;
               end else begin
                  w_k_nxt = r_k + 7'd1;
                  w_load  = 1'b1;
               end
            end
         end
         S_LATCH: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(LE_CYC - 1)) begin
               w_state_nxt = S_DISPLAY;
               w_cnt_nxt   = '0;
            end
         end
         S_DISPLAY: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(HOLD_CYC - 1)) begin
               w_state_nxt = S_BLANK;
               w_cnt_nxt   = '0;
            end
         end
         S_BLANK: begin
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CW'(BLANK_CYC - 1)) begin
               w_cnt_nxt = '0;
               w_k_nxt   = '0;
               if (r_line != LW'(SCANS - 1)) begin
                  w_state_nxt = S_SHIFT;
                  w_line_nxt  = r_line + LW'(1);
                  w_mode_nxt  = I_led_mode;
                  w_load      = 1'b1;
               end else begin
                  // Refresh boundary: the only point where the banks may swap.
                  w_swap     = r_pend;
                  w_bank_nxt = r_pend ? ~r_bank : r_bank;
                  w_line_nxt = '0;
                  if (I_enable) begin
                     w_state_nxt = S_SHIFT;
                     w_mode_nxt  = I_led_mode;
                     w_load      = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Data for the zone about to be presented, looked up with next-cycle bank/line/k.
   always_comb begin
      w_rd_addr = 9'(int'(w_line_nxt) * ZPL + int'(w_k_nxt));
      case (w_mode_nxt)
         2'b00:   w_data_nxt = r_mem[w_bank_nxt][w_rd_addr];
         2'b01:   w_data_nxt = '1;
         2'b10:   w_data_nxt = '0;
         default: w_data_nxt = {DW{w_k_nxt[0]}};
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         r_state <= S_IDLE;
         r_line  <= '0;
         r_k     <= '0;
         r_cnt   <= '0;
         r_mode  <= 2'b00;
         r_bank  <= 1'b0;
         r_pend  <= 1'b0;
         r_swap  <= 1'b0;
         r_ovr   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_line  <= w_line_nxt;
         r_k     <= w_k_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
         r_bank  <= w_bank_nxt;
         r_pend  <= w_swap ? 1'b0 : (r_pend | I_frame_done);
         r_swap  <= w_swap;
         r_ovr   <= I_frame_done & r_pend;
         if (w_load) r_data <= w_data_nxt;
      end
   end

   // NOTE: the zone store has no reset; its contents are defined only by writes.
   always_ff @(posedge I_clk) begin
      if (I_wr_en && (I_wr_addr < 9'(ZONES))) r_mem[~r_bank][I_wr_addr] <= I_wr_data;
   end

   assign O_zone_valid = (r_state == S_SHIFT);
   assign O_zone_data  = r_data;
   assign O_zone_idx   = r_k;
   assign O_le         = (r_state == S_LATCH);
   assign O_scan       = (r_state == S_DISPLAY) ? (SCANS'(1) << r_line) : '0;
   assign O_swap       = r_swap;
   assign O_overrun    = r_ovr;
   assign O_busy       = (r_state != S_IDLE);
endmodule
